// File: rtl/sound_square_channel.sv
`timescale 1ns/1ps
// Square-wave sound channel: duty generator with length counter, volume envelope
// and an optional frequency sweep unit, controlled through five CPU I/O registers.
module sound_square_channel #(
  parameter logic [15:0] BASE_ADDR     = 16'hFF10,
  parameter int          HAS_SWEEP     = 1,
  parameter int          FREQ_TICK_DIV = 8,
  parameter int          FRAME_DIV     = 64453
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic [15:0] I_IOREG_ADDR,
  input  logic [7:0]  I_IOREG_WDATA,
  input  logic        I_IOREG_WE_L,
  output logic [7:0]  O_IOREG_RDATA,
  output logic        O_IOREG_HIT,
  output logic [3:0]  O_SAMPLE,
  output logic        O_ACTIVE
);

  localparam int TW = $clog2(FREQ_TICK_DIV + 1);
  localparam int FW = $clog2(FRAME_DIV + 1);

  logic [15:0]   rel;
  logic          we, wr0, wr1, wr2, wr3, wr4, trigger;
  logic [1:0]    duty;
  logic [7:0]    nr2;
  logic [10:0]   freq;
  logic          len_en;
  logic          enable;
  logic [6:0]    len_cnt;
  logic [11:0]   freq_timer;
  logic [2:0]    duty_step;
  logic [3:0]    volume;
  logic [2:0]    env_timer;
  logic [TW-1:0] tick_cnt;
  logic [FW-1:0] frame_cnt;
  logic [2:0]    frame_step;
  logic [3:0]    sample;
  logic          tick, frame_tick, len_clk, env_clk, dac_on, duty_bit;
  logic [10:0]   trig_freq;
  logic          sweep_ovf_trig, sweep_ovf_clk, sweep_wb;
  logic [10:0]   sweep_wb_freq;
  logic [7:0]    nr0_rd;

  assign rel         = I_IOREG_ADDR - BASE_ADDR;
  assign O_IOREG_HIT = (I_IOREG_ADDR >= BASE_ADDR) && (rel <= 16'd4);
  assign we          = O_IOREG_HIT && !I_IOREG_WE_L;
  assign wr0         = we && (rel == 16'd0);
  assign wr1         = we && (rel == 16'd1);
  assign wr2         = we && (rel == 16'd2);
  assign wr3         = we && (rel == 16'd3);
  assign wr4         = we && (rel == 16'd4);
  assign trigger     = wr4 && I_IOREG_WDATA[7];
  assign trig_freq   = {I_IOREG_WDATA[2:0], freq[7:0]};

  assign tick       = (tick_cnt == TW'(FREQ_TICK_DIV - 1));
  assign frame_tick = (frame_cnt == FW'(FRAME_DIV - 1));
  assign len_clk    = frame_tick && !frame_step[0];
  assign env_clk    = frame_tick && (frame_step == 3'd7);
  assign dac_on     = (nr2[7:3] != 5'd0);

  function automatic logic [11:0] sweep_next(input logic [10:0] s, input logic dec,
                                             input logic [2:0] sh);
    logic [11:0] delta;
    delta = {1'b0, s >> sh};
    return dec ? ({1'b0, s} - delta) : ({1'b0, s} + delta);
  endfunction

  if (HAS_SWEEP != 0) begin : g_sweep
    logic [6:0]  nr0;
    logic [3:0]  sweep_timer, reload;
    logic [10:0] shadow;
    logic [11:0] calc, trig_calc;
    logic        sweep_clk, fire;

    assign sweep_clk      = frame_tick && (frame_step[1:0] == 2'b10);
    assign reload         = (nr0[6:4] == 3'd0) ? 4'd8 : {1'b0, nr0[6:4]};
    assign calc           = sweep_next(shadow, nr0[3], nr0[2:0]);
    assign trig_calc      = sweep_next(trig_freq, nr0[3], nr0[2:0]);
    assign fire           = sweep_clk && !trigger && (sweep_timer <= 4'd1) && (nr0[6:4] != 3'd0);
    assign sweep_ovf_trig = (nr0[2:0] != 3'd0) && trig_calc[11];
    assign sweep_ovf_clk  = fire && calc[11];
    assign sweep_wb       = fire && !calc[11] && (nr0[2:0] != 3'd0);
    assign sweep_wb_freq  = calc[10:0];
    assign nr0_rd         = {1'b1, nr0};

    always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
        nr0         <= '0;
        sweep_timer <= '0;
        shadow      <= '0;
      end else begin
        if (wr0) nr0 <= I_IOREG_WDATA[6:0];
        if (trigger) begin
          sweep_timer <= reload;
          shadow      <= trig_freq;
        end else if (sweep_clk) begin
          if (sweep_timer <= 4'd1) begin
            sweep_timer <= reload;
            if (sweep_wb) shadow <= calc[10:0];
          end else begin
            sweep_timer <= sweep_timer - 4'd1;
          end
        end
      end
    end
  end else begin : g_no_sweep
    assign sweep_ovf_trig = 1'b0;
    assign sweep_ovf_clk  = 1'b0;
    assign sweep_wb       = 1'b0;
    assign sweep_wb_freq  = '0;
    assign nr0_rd         = 8'hFF;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    duty_bit = 1'b0;
    case (duty)
      2'b00:   duty_bit = 8'b0000_0001 >> (3'd7 - duty_step);
      2'b01:   duty_bit = 8'b1000_0001 >> (3'd7 - duty_step);
      2'b10:   duty_bit = 8'b1000_0111 >> (3'd7 - duty_step);
      default: duty_bit = 8'b0111_1110 >> (3'd7 - duty_step);
    endcase
  end

  always_comb begin
    O_IOREG_RDATA = 8'hFF;
    if (O_IOREG_HIT) begin
      case (rel[2:0])
        3'd0:    O_IOREG_RDATA = nr0_rd;
        3'd1:    O_IOREG_RDATA = {duty, 6'h3F};
        3'd2:    O_IOREG_RDATA = nr2;
        3'd4:    O_IOREG_RDATA = {1'b1, len_en, 6'h3F};
        default: O_IOREG_RDATA = 8'hFF;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments; where several assignments to one
  // signal are reachable in a cycle, the last one wins, and that ordering encodes priority.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      duty <= '0; nr2 <= '0; freq <= '0; len_en <= 1'b0; enable <= 1'b0;
      len_cnt <= '0; freq_timer <= '0; duty_step <= '0; volume <= '0; env_timer <= '0;
      tick_cnt <= '0; frame_cnt <= '0; frame_step <= '0; sample <= '0;
    end else begin
      tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
      frame_cnt <= frame_tick ? '0 : frame_cnt + 1'b1;
      if (frame_tick) frame_step <= frame_step + 3'd1;

      if (wr1) duty <= I_IOREG_WDATA[7:6];
      if (wr2) nr2 <= I_IOREG_WDATA;
      if (wr4) len_en <= I_IOREG_WDATA[6];
      // Sweep write-back first so a CPU write to the same register overrides it.
      if (sweep_wb) freq <= sweep_wb_freq;
      if (wr3) freq[7:0] <= I_IOREG_WDATA;
      if (wr4) freq[10:8] <= I_IOREG_WDATA[2:0];

      if (trigger) begin
        freq_timer <= 12'd2048 - {1'b0, trig_freq};
      end else if (tick) begin
        if (freq_timer <= 12'd1) begin
          freq_timer <= 12'd2048 - {1'b0, freq};
          duty_step  <= duty_step + 3'd1;
        end else begin
          freq_timer <= freq_timer - 12'd1;
        end
      end

      if (trigger) begin
        if (len_cnt == 7'd0) len_cnt <= 7'd64;
      end else if (len_clk && len_en && (len_cnt != 7'd0)) begin
        len_cnt <= len_cnt - 7'd1;
        if (len_cnt == 7'd1) enable <= 1'b0;
      end
      if (wr1) len_cnt <= 7'd64 - {1'b0, I_IOREG_WDATA[5:0]};

      if (trigger) begin
        volume    <= nr2[7:4];
        env_timer <= nr2[2:0];
      end else if (env_clk && (nr2[2:0] != 3'd0)) begin
        if (env_timer <= 3'd1) begin
          env_timer <= nr2[2:0];
          if (nr2[3]) begin
            if (volume != 4'd15) volume <= volume + 4'd1;
          end else if (volume != 4'd0) begin
            volume <= volume - 4'd1;
          end
        end else begin
          env_timer <= env_timer - 3'd1;
        end
      end

      if (sweep_ovf_clk) enable <= 1'b0;
      if (trigger) enable <= dac_on && !sweep_ovf_trig;
      if (wr2 && (I_IOREG_WDATA[7:3] == 5'd0)) enable <= 1'b0;

      sample <= (enable && duty_bit) ? volume : 4'd0;
    end
  end

  assign O_SAMPLE = sample;
  assign O_ACTIVE = enable;

endmodule

// File: tb/tb_sound_square_channel.sv
`timescale 1ns/1ps
// Self-checking bench for sound_square_channel: a sweep build and a sweep-less build
// share one register bus; expected values are queued at stimulus time and popped on sampling.
module tb_sound_square_channel;

  localparam logic [15:0] B   = 16'hFF10;
  localparam int          FD  = 32;
  localparam int          FTD = 8;
  localparam int          LIM = 20000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        we_l;
  logic [7:0]  sw_rdata, ns_rdata;
  logic        sw_hit, ns_hit, sw_active, ns_active;
  logic [3:0]  sw_sample, ns_sample;

  always #5 clk = ~clk;

  sound_square_channel #(.BASE_ADDR(B), .HAS_SWEEP(1), .FREQ_TICK_DIV(FTD), .FRAME_DIV(FD)) u_sw (
    .I_CLK(clk), .I_RESET(rst), .I_IOREG_ADDR(addr), .I_IOREG_WDATA(wdata), .I_IOREG_WE_L(we_l),
    .O_IOREG_RDATA(sw_rdata), .O_IOREG_HIT(sw_hit), .O_SAMPLE(sw_sample), .O_ACTIVE(sw_active));

  sound_square_channel #(.BASE_ADDR(B), .HAS_SWEEP(0), .FREQ_TICK_DIV(FTD), .FRAME_DIV(FD)) u_ns (
    .I_CLK(clk), .I_RESET(rst), .I_IOREG_ADDR(addr), .I_IOREG_WDATA(wdata), .I_IOREG_WE_L(we_l),
    .O_IOREG_RDATA(ns_rdata), .O_IOREG_HIT(ns_hit), .O_SAMPLE(ns_sample), .O_ACTIVE(ns_active));

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;
  string tag_q[$];
  int    val_q[$];
  logic [7:0] rd_sw, rd_ns;
  logic       hit_sw, hit_ns;
  int hi, lo, val, mx;

  // Cycles since reset release; frame tick k lands on the edge that makes cyc == k*FD.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int v);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask

  task automatic pop_cmp(input int obs);
    string t;
    int    v;
    if (tag_q.size() == 0) begin
      t = "scoreboard_underflow";
      v = -1;
    end else begin
      t = tag_q.pop_front();
      v = val_q.pop_front();
    end
    check(t, obs, v);
  endtask

  function automatic logic [3:0] smp(input bit sel);
    return sel ? ns_sample : sw_sample;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; we_l = 1'b1; addr = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; wdata = d; we_l = 1'b0;
    @(negedge clk);
    we_l = 1'b1; addr = 16'h0000;
  endtask

  task automatic rd(input logic [15:0] a);
    @(negedge clk);
    addr = a;
    #1;
    rd_sw = sw_rdata; rd_ns = ns_rdata; hit_sw = sw_hit; hit_ns = ns_hit;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic measure_run(input bit sel, output int h, output int l, output int v);
    int n;
    n = 0; while (smp(sel) != 0 && n < LIM) begin @(negedge clk); n++; end
    n = 0; while (smp(sel) == 0 && n < LIM) begin @(negedge clk); n++; end
    v = smp(sel);
    h = 0; while (smp(sel) != 0 && h < LIM) begin @(negedge clk); h++; end
    l = 0; while (smp(sel) == 0 && l < LIM) begin @(negedge clk); l++; end
  endtask

  task automatic max_over(input bit sel, input int n, output int m);
    m = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (int'(smp(sel)) > m) m = int'(smp(sel));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; addr = 16'h0000; wdata = 8'h00; we_l = 1'b1;

    // Reset state and readback masks
    do_reset();
    push_exp("rst_active", 0);   pop_cmp(sw_active);
    push_exp("rst_sample", 0);   pop_cmp(sw_sample);
    rd(B + 16'd0);
    push_exp("rst_nr0_sweep", 8'h80);   pop_cmp(rd_sw);
    push_exp("rst_nr0_nosweep", 8'hFF); pop_cmp(rd_ns);
    rd(B + 16'd1); push_exp("rst_nr1", 8'h3F); pop_cmp(rd_sw);
    rd(B + 16'd2); push_exp("rst_nr2", 8'h00); pop_cmp(rd_sw);
    rd(B + 16'd3); push_exp("rst_nr3", 8'hFF); pop_cmp(rd_sw);
    rd(B + 16'd4);
    push_exp("rst_nr4", 8'hBF);      pop_cmp(rd_sw);
    push_exp("hit_top", 1);          pop_cmp(hit_sw);
    rd(B + 16'd5);
    push_exp("miss_above_hit", 0);   pop_cmp(hit_sw);
    push_exp("miss_above_rd", 8'hFF); pop_cmp(rd_sw);
    rd(B - 16'd1);
    push_exp("miss_below_hit", 0);   pop_cmp(hit_ns);

    // Basic note: duty 10 at freq 0x700, 2048 cycles per duty step
    do_reset();
    wr(B + 16'd2, 8'hF0); wr(B + 16'd3, 8'h00); wr(B + 16'd4, 8'h87);
    push_exp("note_active", 1); pop_cmp(sw_active);
    wr(B + 16'd1, 8'h80);
    rd(B + 16'd1); push_exp("note_nr1_rd", 8'hBF); pop_cmp(rd_sw);
    push_exp("note_hi_val", 15); push_exp("note_hi_len", 4 * 2048); push_exp("note_lo_len", 4 * 2048);
    measure_run(1'b0, hi, lo, val);
    pop_cmp(val); pop_cmp(hi); pop_cmp(lo);

    // Length counter of 1 expires on the first length clock
    do_reset();
    wr(B + 16'd2, 8'hF0); wr(B + 16'd1, 8'h3F); wr(B + 16'd4, 8'hC0);
    push_exp("len_active_trig", 1); pop_cmp(sw_active);
    rd(B + 16'd4); push_exp("len_nr4_rd", 8'hFF); pop_cmp(rd_sw);
    wait_cyc(FD - 1);
    push_exp("len_active_before", 1); pop_cmp(ns_active);
    wait_cyc(FD);
    push_exp("len_active_after_sw", 0); pop_cmp(sw_active);
    push_exp("len_active_after_ns", 0); pop_cmp(ns_active);

    // Sweep overflow: 0x700 + (0x700>>1) = 0xA80 > 2047
    do_reset();
    wr(B + 16'd0, 8'h11); wr(B + 16'd2, 8'hF0); wr(B + 16'd3, 8'h00); wr(B + 16'd4, 8'h87);
    push_exp("ovf_trig_sw", 0); pop_cmp(sw_active);
    push_exp("ovf_trig_ns", 1); pop_cmp(ns_active);
    rd(B + 16'd0);
    push_exp("ovf_nr0_sw", 8'h91); pop_cmp(rd_sw);
    push_exp("ovf_nr0_ns", 8'hFF); pop_cmp(rd_ns);
    wait_cyc(3 * FD);
    push_exp("ovf_after_sweep_clk", 0); pop_cmp(sw_active);

    // Shift 0 with period 1 keeps the channel running
    do_reset();
    wr(B + 16'd0, 8'h10); wr(B + 16'd2, 8'hF0); wr(B + 16'd3, 8'h00); wr(B + 16'd4, 8'h81);
    push_exp("shift0_trig", 1); pop_cmp(sw_active);
    wait_cyc(7 * FD + 2);
    push_exp("shift0_after_2_clks", 1); pop_cmp(sw_active);

    // Sweep write-back: 0x200 -> 0x300 -> 0x480 -> 0x6C0 -> 0xA20 overflows on the 4th clock
    do_reset();
    wr(B + 16'd0, 8'h11); wr(B + 16'd2, 8'hF0); wr(B + 16'd3, 8'h00); wr(B + 16'd4, 8'h82);
    push_exp("wb_trig", 1); pop_cmp(sw_active);
    wait_cyc(15 * FD - 1);
    push_exp("wb_before_4th", 1); pop_cmp(sw_active);
    wait_cyc(15 * FD);
    push_exp("wb_after_4th", 0);  pop_cmp(sw_active);
    push_exp("wb_nosweep_on", 1); pop_cmp(ns_active);

    // Sweep-less build: NRx0 write ignored, frequency 0x7FE holds (16-cycle steps)
    do_reset();
    wr(B + 16'd0, 8'h11); wr(B + 16'd2, 8'hF0); wr(B + 16'd1, 8'h00);
    wr(B + 16'd3, 8'hFE); wr(B + 16'd4, 8'h87);
    push_exp("ns_sw_ovf", 0); pop_cmp(sw_active);
    rd(B + 16'd0); push_exp("ns_nr0_rd", 8'hFF); pop_cmp(rd_ns);
    wait_cyc(8 * FD);
    push_exp("ns_hi_val", 15); push_exp("ns_hi_len", 16); push_exp("ns_lo_len", 112);
    measure_run(1'b1, hi, lo, val);
    pop_cmp(val); pop_cmp(hi); pop_cmp(lo);
    push_exp("ns_active", 1); pop_cmp(ns_active);

    // Envelope up from 0, period 3: volume = min(15, clocks/3), clocks every 8*FD cycles
    do_reset();
    wr(B + 16'd2, 8'h0B); wr(B + 16'd1, 8'hC0); wr(B + 16'd3, 8'hFF); wr(B + 16'd4, 8'h87);
    push_exp("env_active", 1); pop_cmp(sw_active);
    push_exp("env_vol_7", 2);   wait_cyc(8 * FD * 7 + 8);  max_over(1'b0, 64, mx); pop_cmp(mx);
    push_exp("env_vol_44", 14); wait_cyc(8 * FD * 44 + 8); max_over(1'b0, 64, mx); pop_cmp(mx);
    push_exp("env_vol_45", 15); wait_cyc(8 * FD * 45 + 8); max_over(1'b0, 64, mx); pop_cmp(mx);
    push_exp("env_vol_50", 15); wait_cyc(8 * FD * 50 + 8); max_over(1'b0, 64, mx); pop_cmp(mx);

    // Reset mid-note silences on the next edge; triggers during reset are ignored
    push_exp("midrst_pre_active", 1); pop_cmp(sw_active);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    push_exp("midrst_sample", 0); pop_cmp(sw_sample);
    push_exp("midrst_active", 0); pop_cmp(sw_active);
    wr(B + 16'd2, 8'hF0); wr(B + 16'd4, 8'h87);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    push_exp("rst_trig_ignored", 0); pop_cmp(sw_active);
    rd(B + 16'd2); push_exp("rst_wr_ignored", 8'h00); pop_cmp(rd_sw);

    // DAC off while playing
    do_reset();
    wr(B + 16'd2, 8'hF0); wr(B + 16'd1, 8'hC0); wr(B + 16'd3, 8'hFF); wr(B + 16'd4, 8'hC7);
    push_exp("dac_active", 1); pop_cmp(sw_active);
    rd(B + 16'd4); push_exp("dac_nr4_rd", 8'hFF); pop_cmp(rd_sw);
    for (int i = 0; i < 200 && sw_sample == 0; i++) @(negedge clk);
    push_exp("dac_sample_pre", 15); pop_cmp(sw_sample);
    wr(B + 16'd2, 8'h00);
    push_exp("dac_off_active", 0); pop_cmp(sw_active);
    @(negedge clk);
    push_exp("dac_off_sample", 0); pop_cmp(sw_sample);
    rd(B + 16'd4); push_exp("dac_off_nr4_rd", 8'hFF); pop_cmp(rd_sw);
    rd(B + 16'd2); push_exp("dac_off_nr2_rd", 8'h00); pop_cmp(rd_sw);

    check("scoreboard_drained", tag_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sound_square_channel.md
SOUND_SQUARE_CHANNEL -- requirements
Module: sound_square_channel

Interface
REQ-001 SHALL provide parameter BASE_ADDR, default 16'hFF10: address of register NRx0; NRx1..NRx4 follow at +1..+4.
REQ-002 SHALL provide parameter HAS_SWEEP, default 1: 1 builds a channel-1 style block with frequency sweep, 0 builds a channel-2 style block without it.
REQ-003 SHALL provide parameter FREQ_TICK_DIV, default 8: I_CLK cycles per frequency-timer tick.
REQ-004 SHALL provide parameter FRAME_DIV, default 64453: I_CLK cycles per 512 Hz frame-sequencer step.
REQ-005 I_CLK  input  1  system clock; all state updates on its rising edge.
REQ-006 I_RESET  input  1  synchronous, active-high reset.
REQ-007 I_IOREG_ADDR  input  16  CPU I/O register address.
REQ-008 I_IOREG_WDATA  input  8  CPU write data.
REQ-009 I_IOREG_WE_L  input  1  active-low write strobe; one write per low cycle.
REQ-010 O_IOREG_RDATA  output  8  combinational readback for the addressed register, 8'hFF when the address is not a channel register.
REQ-011 O_IOREG_HIT  output  1  high when I_IOREG_ADDR is in BASE_ADDR..BASE_ADDR+4.
REQ-012 O_SAMPLE  output  4  unsigned channel amplitude, registered.
REQ-013 O_ACTIVE  output  1  channel-enabled status, for NR52 bits.

Function
REQ-014 Register fields SHALL be:
- NRx0: [6:4] sweep period, [3] decrease, [2:0] shift.
- NRx1: [7:6] duty, [5:0] length load.
- NRx2: [7:4] initial volume, [3] increase, [2:0] envelope period.
- NRx3: frequency low 8 bits.
- NRx4: [7] trigger (write-only), [6] length enable, [2:0] frequency high.
REQ-015 Readback masks SHALL be: NRx0 = data|8'h80; NRx1 = data|8'h3F; NRx2 = data; NRx3 = 8'hFF; NRx4 = data|8'hBF.
REQ-016 With HAS_SWEEP=0, NRx0 SHALL read 8'hFF, writes SHALL be ignored, and no sweep logic SHALL be built.
REQ-017 The frame sequencer SHALL keep a 3-bit step, advanced every FRAME_DIV cycles and wrapping 7->0.
- Length clock on steps 0, 2, 4 and 6.
- Sweep clock on steps 2 and 6.
- Envelope clock on step 7.
REQ-018 A write to NRx1 SHALL load the 7-bit length counter with 64 - NRx1[5:0].
REQ-019 On a length clock with NRx4[6]=1 and a nonzero counter, the counter SHALL decrement; reaching 0 SHALL clear enable on the same edge.
REQ-020 A write to NRx4 with bit 7 set SHALL trigger:
- enable=1 if DAC on (NRx2[7:3]!=0);
- length counter 0 -> 64;
- frequency timer <- 2048 - freq;
- volume <- NRx2[7:4];
- envelope timer <- NRx2[2:0];
- shadow frequency <- {NRx4[2:0],NRx3};
- sweep timer <- period (8 if period is 0).
REQ-021 On trigger with HAS_SWEEP=1 and shift!=0, an overflow calculation (REQ-023) SHALL run immediately; overflow clears enable.
REQ-022 Sweep clock: sweep timer decrements; at 0 it SHALL reload (8 if period 0), and if period!=0 compute new = shadow ± (shadow>>shift) in 12 bits.
REQ-023 If new > 2047, enable SHALL clear. Otherwise, if shift!=0, new SHALL be written to shadow, NRx3 and NRx4[2:0].
REQ-024 Envelope clock with period!=0: timer decrements; at 0 it SHALL reload and step volume by ±1, saturating at 15/0. Period 0 freezes volume.
REQ-025 The frequency timer SHALL decrement once per FREQ_TICK_DIV cycles; at 0 it SHALL reload 2048 - freq and advance the 3-bit duty step (wrap 7->0).
REQ-026 Duty patterns, step 0..7: 00=00000001, 01=10000001, 10=10000111, 11=01111110.
REQ-027 O_SAMPLE SHALL be volume when enable and the duty bit are both 1, else 0; it updates one cycle after the state change.
REQ-028 A write making NRx2[7:3]==0 SHALL clear enable on that edge.
REQ-029 Same-cycle conflicts: trigger SHALL win over length, sweep and envelope clocks. A register write SHALL win over a sweep write-back to NRx3/NRx4.
REQ-030 O_ACTIVE SHALL equal enable.

Reset
REQ-031 I_RESET SHALL clear all registers, counters, the duty step, the frame step, enable, O_SAMPLE and O_ACTIVE to 0. Reset mid-note SHALL silence the output on the next edge; triggers are ignored while I_RESET=1.

Verification
REQ-032 Reset, then write NRx2=F0, NRx3=00, NRx4=87, NRx1=80 -> O_ACTIVE=1; O_SAMPLE follows 10000111 at 15, step period 8*(2048-1792)=2048 cycles.
REQ-033 NRx1=3F, NRx4=C0|trigger -> enable clears on the first length clock.
REQ-034 HAS_SWEEP=1, NRx0=11, freq 0x700, trigger -> after the first sweep clock freq = 0x700+0x380 = 0xA80 > 2047, so enable clears. Also check that a shift=0 trigger with period 1 keeps the channel enabled.
REQ-035 NRx2=0B (volume 0, increase, period 3) -> volume reaches 15 after 45 envelope clocks and stays at 15.
REQ-036 Write NRx2=00 while active -> O_ACTIVE=0 next edge, O_SAMPLE=0; NRx4 reads 8'hBF|(bit6).
REQ-037 HAS_SWEEP=0: NRx0 reads FF, writes to it have no effect, and the frequency stays constant.
